// File: rtl/apb_seg_charlcd.sv
// apb_seg_charlcd: APB peripheral driving a 2x16 HD44780 LCD, a 4-digit 7-segment display and 8 LEDs.
// LCDCLK is only a timing reference; all logic runs on PCLK.
module apb_seg_charlcd #(
  parameter int unsigned PWRUP_TICKS = 150000,
  parameter int unsigned CMD_TICKS   = 400,
  parameter int unsigned CLR_TICKS   = 16000,
  parameter int unsigned SCAN_TICKS  = 10000
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic [7:0]  PADDR,
  input  logic        PENABLE,
  input  logic        PSEL,
  input  logic        PWRITE,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  input  logic        LCDCLK,
  output logic        LCD_RS,
  output logic        LCD_RW,
  output logic        LCD_EN,
  output logic [7:0]  LCD_DATA,
  output logic [7:0]  SEGOUT,
  output logic [3:0]  SEGCOM,
  output logic [7:0]  LED_OUT,
  input  logic        blink,
  input  logic        shift
);
  typedef enum logic [1:0] {PWRUP, XFER, WAIT} state_t;
  localparam logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d, scan_q, scan_d;
  logic [1:0]  ph_q, ph_d, dig_q, dig_d;
  logic [5:0]  idx_q, idx_d;
  logic        init_done_q, init_done_d, rs_q, rs_d, en_q, en_d;
  logic [7:0]  data_q, data_d, led_q, led_d, segout_q, segout_d;
  logic [3:0]  segcom_q, segcom_d;
  logic [15:0] seg_q, seg_d;
  logic [7:0]  cbuf_q [32];
  logic [7:0]  cbuf_d [32];
  logic [2:0]  lsync_q;
  logic        tick, wr, buf_hit, nrs, last, busy;
  logic [4:0]  bi;
  logic [7:0]  nbyte;
  logic [3:0]  nib;
  logic [31:0] rdata;
  assign tick    = lsync_q[1] & ~lsync_q[2];
  assign wr      = PSEL & PENABLE & PWRITE;
  assign buf_hit = (PADDR[7:5] == 3'b010) && (PADDR[1:0] == 2'b00);
  assign busy    = state_q != PWRUP;
  assign bi      = (idx_q < 6'd18) ? 5'(idx_q - 6'd2) : 5'(idx_q - 6'd3);
  assign nib     = 4'(seg_q >> {dig_q, 2'b00});
  // Refresh pass slots: 0 ctrl, 1 line1 addr, 2-17 line1, 18 line2 addr, 19-34 line2, 35 shift
  always_comb begin
    nrs   = init_done_q && ((idx_q >= 6'd2 && idx_q <= 6'd17) || (idx_q >= 6'd19 && idx_q <= 6'd34));
    nbyte = !init_done_q ? (idx_q == 6'd0 ? 8'h38 : idx_q == 6'd1 ? 8'h0C : idx_q == 6'd2 ? 8'h01 : 8'h06)
          : idx_q == 6'd0  ? {7'b0000110, blink}
          : idx_q == 6'd1  ? 8'h80
          : idx_q == 6'd18 ? 8'hC0
          : idx_q == 6'd35 ? 8'h18 : cbuf_q[bi];
    last  = init_done_q ? (idx_q == 6'd35 || (idx_q == 6'd34 && !shift)) : idx_q == 6'd3;
  end
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ph_d        = ph_q;
    idx_d       = idx_q;
    init_done_d = init_done_q;
    rs_d        = rs_q;
    en_d        = en_q;
    data_d      = data_q;
    if (tick) begin
      case (state_q)
        PWRUP: begin
          state_d = (cnt_q == 32'd0) ? XFER : PWRUP;
          cnt_d   = (cnt_q == 32'd0) ? 32'd0 : cnt_q - 32'd1;
          ph_d    = 2'd0;
        end
        XFER: begin
          ph_d    = ph_q + 2'd1;
          en_d    = (ph_q == 2'd1) || (ph_q == 2'd2);
          rs_d    = (ph_q == 2'd0) ? nrs : rs_q;
          data_d  = (ph_q == 2'd0) ? nbyte : data_q;
          state_d = (ph_q == 2'd3) ? WAIT : XFER;
          cnt_d   = (!rs_q && data_q == 8'h01) ? 32'(CLR_TICKS - 1) : 32'(CMD_TICKS - 1);
        end
        default: begin
          state_d     = (cnt_q == 32'd0) ? XFER : WAIT;
          cnt_d       = (cnt_q == 32'd0) ? 32'd0 : cnt_q - 32'd1;
          idx_d       = (cnt_q != 32'd0) ? idx_q : last ? 6'd0 : idx_q + 6'd1;
          init_done_d = init_done_q | ((cnt_q == 32'd0) && last);
        end
      endcase
    end
  end
  always_comb begin
    seg_d  = (wr && PADDR == 8'h00) ? PWDATA[15:0] : seg_q;
    led_d  = (wr && PADDR == 8'h04) ? PWDATA[7:0] : led_q;
    cbuf_d = cbuf_q;
    for (int i = 0; i < 4; i++)
      if (wr && buf_hit) cbuf_d[{PADDR[4:2], 2'(i)}] = PWDATA[8*i +: 8];
    scan_d   = !tick ? scan_q : (scan_q == 32'(SCAN_TICKS - 1)) ? 32'd0 : scan_q + 32'd1;
    dig_d    = (tick && scan_q == 32'(SCAN_TICKS - 1)) ? dig_q + 2'd1 : dig_q;
    segcom_d = ~(4'b0001 << dig_q);
    segout_d = {1'b0, HEX[nib]};
    rdata    = PADDR == 8'h00 ? {16'b0, seg_q}
             : PADDR == 8'h04 ? {24'b0, led_q}
             : PADDR == 8'h08 ? {30'b0, init_done_q, busy}
             : buf_hit ? {cbuf_q[{PADDR[4:2], 2'd3}], cbuf_q[{PADDR[4:2], 2'd2}],
                          cbuf_q[{PADDR[4:2], 2'd1}], cbuf_q[{PADDR[4:2], 2'd0}]} : 32'b0;
  end
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= PWRUP;
      cnt_q       <= 32'(PWRUP_TICKS - 1);
      ph_q        <= 2'd0;
      idx_q       <= 6'd0;
      init_done_q <= 1'b0;
      rs_q        <= 1'b0;
      en_q        <= 1'b0;
      data_q      <= 8'h00;
      lsync_q     <= 3'b000;
      seg_q       <= 16'h0000;
      led_q       <= 8'h00;
      scan_q      <= 32'd0;
      dig_q       <= 2'd0;
      segout_q    <= 8'h00;
      segcom_q    <= 4'hF;
      for (int i = 0; i < 32; i++) cbuf_q[i] <= 8'h20;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ph_q        <= ph_d;
      idx_q       <= idx_d;
      init_done_q <= init_done_d;
      rs_q        <= rs_d;
      en_q        <= en_d;
      data_q      <= data_d;
      lsync_q     <= {lsync_q[1:0], LCDCLK};
      seg_q       <= seg_d;
      led_q       <= led_d;
      scan_q      <= scan_d;
      dig_q       <= dig_d;
      segout_q    <= segout_d;
      segcom_q    <= segcom_d;
      cbuf_q      <= cbuf_d;
    end
  end
  assign PRDATA   = (PSEL && !PWRITE) ? rdata : 32'b0;
  assign LCD_RS   = rs_q;
  assign LCD_RW   = 1'b0;
  assign LCD_EN   = en_q;
  assign LCD_DATA = data_q;
  assign SEGOUT   = segout_q;
  assign SEGCOM   = segcom_q;
  assign LED_OUT  = led_q;
endmodule

// File: tb/tb_apb_seg_charlcd.sv
// tb_apb_seg_charlcd: directed bench; expected LCD bytes are queued up front and
// checked, with their timing, as each EN pulse appears.
module tb_apb_seg_charlcd;
  localparam int PW = 60, CMD = 3, CLR = 6, SCAN = 4;
  logic        PCLK = 0, PRESETn = 0, PENABLE = 0, PSEL = 0, PWRITE = 0, LCDCLK = 0;
  logic [7:0]  PADDR = 0;
  logic [31:0] PWDATA = 0, PRDATA, rd;
  logic        LCD_RS, LCD_RW, LCD_EN, blink = 0, shift = 0;
  logic [7:0]  LCD_DATA, SEGOUT, LED_OUT;
  logic [3:0]  SEGCOM, pc;
  int          checks = 0, errors = 0;
  logic [8:0]  sb [$];
  logic [11:0] sq [$];
  logic [7:0]  mbuf [32];

  apb_seg_charlcd #(.PWRUP_TICKS(PW), .CMD_TICKS(CMD), .CLR_TICKS(CLR), .SCAN_TICKS(SCAN)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(PADDR), .PENABLE(PENABLE), .PSEL(PSEL),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .LCDCLK(LCDCLK), .LCD_RS(LCD_RS),
    .LCD_RW(LCD_RW), .LCD_EN(LCD_EN), .LCD_DATA(LCD_DATA), .SEGOUT(SEGOUT), .SEGCOM(SEGCOM),
    .LED_OUT(LED_OUT), .blink(blink), .shift(shift));

  always #5 PCLK = ~PCLK;
  always #50 LCDCLK = ~LCDCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Monitor: one scoreboard entry per EN rising edge, plus pulse width and spacing
  int         cyc = 0, last_rise = 0;
  logic       en_prev = 0, have_prev = 0;
  logic [8:0] prev, cur;
  always @(negedge PCLK) begin
    if (!PRESETn) begin
      cyc = 0; en_prev = 0; have_prev = 0;
    end else begin
      cyc++;
      if (LCD_EN && !en_prev) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $error("FAIL lcd_extra_byte: observed %h with nothing expected", {LCD_RS, LCD_DATA});
        end else begin
          cur = sb.pop_front();
          chk("lcd_byte", {23'b0, LCD_RS, LCD_DATA}, {23'b0, cur});
          chk("lcd_rw", {31'b0, LCD_RW}, 32'd0);
          if (have_prev) chk("lcd_gap", cyc - last_rise, (4 + ((prev == 9'h001) ? CLR : CMD)) * 10);
          else chk("pwrup_delay", {31'b0, cyc >= (PW + 1) * 10 && cyc <= (PW + 3) * 10}, 32'd1);
          prev = cur; have_prev = 1; last_rise = cyc;
        end
      end
      if (!LCD_EN && en_prev) begin
        chk("lcd_en_width", cyc - last_rise, 20);
        chk("lcd_data_hold", {23'b0, LCD_RS, LCD_DATA}, {23'b0, prev});
      end
      en_prev = LCD_EN;
    end
  end

  task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
    @(posedge PCLK); #1 PSEL = 1; PWRITE = 1; PADDR = a; PWDATA = d; PENABLE = 0;
    @(posedge PCLK); #1 PENABLE = 1;
    @(posedge PCLK); #1 PSEL = 0; PENABLE = 0; PWRITE = 0;
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [31:0] d);
    @(posedge PCLK); #1 PSEL = 1; PWRITE = 0; PADDR = a; PENABLE = 0;
    @(posedge PCLK); #1 PENABLE = 1;
    @(negedge PCLK); d = PRDATA;
    @(posedge PCLK); #1 PSEL = 0; PENABLE = 0;
  endtask

  task automatic push_init();
    sb.push_back(9'h038); sb.push_back(9'h00C); sb.push_back(9'h001); sb.push_back(9'h006);
  endtask

  task automatic push_pass(input logic bl, input logic sh);
    sb.push_back({2'b00, 6'b000110, bl});
    sb.push_back(9'h080);
    for (int i = 0; i < 16; i++) sb.push_back({1'b1, mbuf[i]});
    sb.push_back(9'h0C0);
    for (int i = 16; i < 32; i++) sb.push_back({1'b1, mbuf[i]});
    if (sh) sb.push_back(9'h018);
  endtask

  task automatic wait_size(input int n, input string tag);
    int k = 0;
    while (sb.size() > n && k < 20000) begin @(negedge PCLK); k++; end
    chk(tag, {31'b0, sb.size() <= n}, 32'd1);
  endtask

  task automatic seg_step(input string tag);
    int k = 0;
    pc = SEGCOM;
    while (SEGCOM == pc && k < 200) begin @(negedge PCLK); k++; end
    cur = 9'h0;
    chk(tag, {20'b0, SEGCOM, SEGOUT}, {20'b0, sq.pop_front()});
  endtask

  task automatic check_reset_outputs();
    chk("rst_lcd", {20'b0, LCD_RS, LCD_RW, LCD_EN, LCD_DATA}, 32'd0);
    chk("rst_segout", {24'b0, SEGOUT}, 32'd0);
    chk("rst_segcom", {28'b0, SEGCOM}, 32'hF);
    chk("rst_led", {24'b0, LED_OUT}, 32'd0);
    chk("rst_prdata", PRDATA, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mbuf[i] = 8'h20;
    repeat (5) @(negedge PCLK);
    check_reset_outputs();
    push_init();
    @(posedge PCLK); #1 PRESETn = 1;
    apb_write(8'h04, 32'h000000A5);
    @(negedge PCLK); chk("led_out", {24'b0, LED_OUT}, 32'hA5);
    apb_read(8'h04, rd); chk("rd_led", rd, 32'hA5);
    apb_read(8'h20, rd); chk("rd_unmapped", rd, 32'h0);
    apb_read(8'h00, rd); chk("rd_seg_reset", rd, 32'h0);
    apb_write(8'h40, 32'h44434241);
    mbuf[0] = 8'h41; mbuf[1] = 8'h42; mbuf[2] = 8'h43; mbuf[3] = 8'h44;
    apb_read(8'h40, rd); chk("rd_buf0", rd, 32'h44434241);
    apb_read(8'h44, rd); chk("rd_buf1_reset", rd, 32'h20202020);
    apb_write(8'h00, 32'h00001234);
    apb_read(8'h00, rd); chk("rd_seg", rd, 32'h1234);
    push_pass(0, 0);
    // Digit scan, including wrap from digit 3 back to digit 0
    sq.push_back(12'hE66); sq.push_back(12'hD4F); sq.push_back(12'hB5B);
    sq.push_back(12'h706); sq.push_back(12'hE66);
    begin
      int k = 0;
      pc = SEGCOM;
      @(negedge PCLK);
      while (!(SEGCOM == 4'hE && pc != 4'hE) && k < 400) begin pc = SEGCOM; @(negedge PCLK); k++; end
      chk("seg_d0", {20'b0, SEGCOM, SEGOUT}, {20'b0, sq.pop_front()});
    end
    seg_step("seg_d1"); seg_step("seg_d2"); seg_step("seg_d3"); seg_step("seg_wrap");
    wait_size(37, "wait_first_cmd");
    apb_read(8'h08, rd); chk("status_init_busy", rd, 32'h1);
    wait_size(33, "wait_pass1_start");
    apb_read(8'h08, rd); chk("status_done_busy", rd, 32'h3);
    wait_size(0, "wait_pass1_end");
    blink = 1;
    apb_write(8'h58, 32'h5A595857);
    mbuf[24] = 8'h57; mbuf[25] = 8'h58; mbuf[26] = 8'h59; mbuf[27] = 8'h5A;
    push_pass(1, 1);
    wait_size(35, "wait_pass2_start");
    shift = 1;
    wait_size(33, "wait_pass2_char0");
    apb_write(8'h40, 32'h44434261);
    mbuf[0] = 8'h61;
    wait_size(0, "wait_pass2_end");
    blink = 0;
    push_pass(0, 1);
    wait_size(26, "wait_pass3_mid");
    PRESETn = 0;
    sb.delete();
    repeat (5) @(negedge PCLK);
    check_reset_outputs();
    repeat (5) @(negedge PCLK);
    @(posedge PCLK); #1 PRESETn = 1;
    for (int i = 0; i < 32; i++) mbuf[i] = 8'h20;
    apb_read(8'h04, rd); chk("rd_led_after_rst", rd, 32'h0);
    apb_read(8'h00, rd); chk("rd_seg_after_rst", rd, 32'h0);
    apb_read(8'h40, rd); chk("rd_buf_after_rst", rd, 32'h20202020);
    apb_read(8'h08, rd); chk("status_init_cleared", {31'b0, rd[1]}, 32'd0);
    push_init();
    sb.push_back(9'h00C);
    wait_size(0, "wait_restart");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
